// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant between core and external
// requester, fixed-latency access sequencing, registered read data and ack.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_stall,
  input  logic        e_req,
  input  logic        e_we,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_wdata,
  output logic [31:0] e_rdata,
  output logic        e_ack,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] crd_q, crd_d;
  logic [31:0] erd_q, erd_d;
  logic        gnt_ext;

  // On contention the side that was not granted last wins.
  assign gnt_ext = e_req & (~c_req | ~last_q);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      erd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      erd_q   <= erd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    erd_d   = erd_q;
    unique case (state_q)
      S_IDLE: begin
        if (c_req | e_req) begin
          owner_d = gnt_ext;
          last_d  = gnt_ext;
          we_d    = gnt_ext ? e_we    : c_we;
          addr_d  = gnt_ext ? e_addr  : c_addr;
          wdata_d = gnt_ext ? e_wdata : c_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) erd_d = m_rdata;
            else         crd_d = m_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_we    = (state_q == S_ACCESS) &  we_q;
  assign m_re    = (state_q == S_ACCESS) & ~we_q;
  assign c_ack   = (state_q == S_DONE) & ~owner_q;
  assign e_ack   = (state_q == S_DONE) &  owner_q;
  assign c_stall = c_req & ~c_ack;
  assign c_rdata = crd_q;
  assign e_rdata = erd_q;
  assign owner   = owner_q;
  assign busy    = (state_q != S_IDLE);

  a_rw_excl: assert property (@(posedge clock) disable iff (!Reset) !(m_we && m_re));
  a_ack_excl: assert property (@(posedge clock) disable iff (!Reset) !(c_ack && e_ack));

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the data memory (`dmem`). It shares the single `memread`/`memwrite` data-memory port between the core load/store path and an external requester (debug loader/DMA). It runs each access as a fixed-latency, multi-cycle transaction, returns read data with a one-cycle acknowledge, and stalls whichever side is waiting. It sits between the core datapath (ALU result/ReadData2 path) and `dmem`.

## Interface

Parameters:
- MEM_LAT, 1: cycles the memory port is driven per access; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; must be held with its operands until `c_ack`.
- c_we  in  1  core request type: 1 = store, 0 = load.
- c_addr  in  32  core byte address.
- c_wdata  in  32  core store data.
- c_rdata  out  32  core load data, registered; valid in the `c_ack` cycle and held until the next core completion.
- c_ack  out  1  one-cycle completion pulse to the core.
- c_stall  out  1  `c_req & ~c_ack` (combinational); freezes the PC.
- e_req, e_we, e_addr, e_wdata  in  1/1/32/32  external request; same rules as the core.
- e_rdata  out  32  external load data; same rules as `c_rdata`.
- e_ack  out  1  one-cycle completion pulse to the external requester.
- m_addr  out  32  memory address, registered.
- m_wdata  out  32  memory write data, registered.
- m_we  out  1  memory write enable (`memwrite`).
- m_re  out  1  memory read enable (`memread`).
- m_rdata  in  32  memory read data.
- owner  out  1  current or last grantee: 0 = core, 1 = external.
- busy  out  1  high in ACCESS and DONE.

## Operation

- FSM states: IDLE, ACCESS, DONE. A 4-bit down-counter `cnt` and a 1-bit `last` (last grantee) are also kept.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If only one request is high, grant it.
  - If both are high, grant the requester that is not `last` (round-robin).
  - On a grant, latch the grantee's addr, we and wdata into the m_* registers; set `owner` and `last` to the grantee; load `cnt = MEM_LAT-1`; go to ACCESS.
- **ACCESS**
  - Drive `m_we = latched we` and `m_re = ~latched we`.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`: for a load, capture `m_rdata` into the owner's rdata register; go to DONE.
- **DONE**
  - `m_we = m_re = 0`.
  - Pulse the owner's ack; the other side's ack stays 0.
  - Go to IDLE unconditionally.
- **Held request:** a request still high in the IDLE cycle after its ack is a new transaction.
- **Request dropped during ACCESS:** the drop is ignored. The transaction completes and the ack still pulses.
- **Operand changes during ACCESS:** ignored, because the operands were latched at grant.
- **Stores:** rdata registers are unchanged.
- **IDLE outputs:** `m_we = m_re = 0`; m_addr and m_wdata hold their last values.
- **Reset values (Reset low, asynchronous):**
  - State = IDLE, `cnt` = 0, `last` = 1 (so the core wins the first contention).
  - `owner`, `busy`, `m_we`, `m_re`, `c_ack`, `e_ack` = 0.
  - `m_addr`, `m_wdata`, `c_rdata`, `e_rdata` = 0.
- **Reset mid-transaction:** the transaction is abandoned. `m_we` drops immediately and no ack is issued. After Reset is released, arbitration restarts from the reset state.

## Timing

- Cycle numbering: cycle 0 is the first cycle a request is high while the FSM is in IDLE. The grant is taken at the end of cycle 0.
- ACCESS occupies cycles 1..MEM_LAT, with `m_re`/`m_we` high for exactly MEM_LAT cycles.
- DONE and the ack occur in cycle MEM_LAT+1. Uncontended latency from request to ack is MEM_LAT+1 cycles.
- Load data is sampled on the last ACCESS edge and visible on rdata in the ack cycle.
- Transaction spacing:
  - Minimum spacing between acks is MEM_LAT+2 cycles, because IDLE always costs one cycle.
  - Contended back-to-back throughput alternates grantees, one transaction every MEM_LAT+2 cycles.
- Simultaneous events:
  - An ack to one side and a new request from the other in the same cycle: the new request is granted in the following IDLE cycle.
  - The loser of an arbitration keeps its stall high until its own ack.

## Test plan

- **Reset:** assert Reset low mid-run -> all outputs listed above read 0 within the same cycle. After release, `busy = 0` and the FSM is in IDLE.
- **Core load, MEM_LAT=2, uncontended:** `c_req=1`, `c_we=0`, `c_addr=0x10`, memory returns `0xDEADBEEF` ->
  - `m_re = 1` with `m_addr = 0x10` in cycles 1-2.
  - `c_ack = 1` and `c_rdata = 0xDEADBEEF` in cycle 3.
  - `c_stall = 1` in cycles 0-2.
- **External store, MEM_LAT=1:** `e_addr=0x20`, `e_wdata=0x12345678` ->
  - `m_we = 1` in cycle 1 only, and `m_re` stays 0.
  - `e_ack` pulses in cycle 2; `c_ack` stays 0.
  - `c_rdata` and `e_rdata` are unchanged.
- **Contention after reset, MEM_LAT=1:** `c_req` and `e_req` both rise in the same cycle and are held ->
  - Core is granted first: `owner = 0`, `c_ack` in cycle 2.
  - External is granted next: `owner = 1`, `e_ack` in cycle 5.
- **Sustained contention:** both requests held high for 4 transactions -> grant order is core, ext, core, ext, with acks exactly MEM_LAT+2 cycles apart.
- **Reset mid-ACCESS:** MEM_LAT=4, core store; pull Reset low in cycle 2 ->
  - `m_we` falls asynchronously and no `c_ack` occurs.
  - After release with `e_req` and `c_req` both high, the core is granted first.
